// File: rtl/data_mem_if.sv
// Data-memory request/grant/valid bus between a core LSU (master) and a data memory (slave).
`timescale 1ns/1ps
interface data_mem_if;
  logic        data_req;
  logic        data_wr;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [3:0]  data_be;
  logic        data_gnt;
  logic [31:0] data_rdata;
  logic        data_valid;
  logic        data_error;

  modport master (
    output data_req, data_wr, data_addr, data_wdata, data_be,
    input  data_gnt, data_rdata, data_valid, data_error
  );

  modport slave (
    input  data_req, data_wr, data_addr, data_wdata, data_be,
    output data_gnt, data_rdata, data_valid, data_error
  );
endinterface

// File: rtl/data_mem_responder.sv
// Word-addressed, byte-writable data RAM answering req/gnt requests with in-order,
// fixed-latency responses and a bound on granted-but-unanswered accesses.
`timescale 1ns/1ps
module data_mem_responder #(
  parameter logic [31:0] ADDR_BASE       = 32'h0001_0000,
  parameter int          DEPTH_WORDS     = 1024,
  parameter int          LATENCY         = 1,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic       clk,
  input  logic       reset,
  data_mem_if.slave  bus
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  logic [31:0] mem [DEPTH_WORDS];

  logic [31:0]      off;
  logic             hit;
  logic [IDX_W-1:0] idx;
  logic             grant;
  logic             rsp_now;
  logic [31:0]      rsp_word;
  logic [CNT_W-1:0] cnt;

  logic [LATENCY-1:0]       pipe_valid;
  logic [LATENCY-1:0]       pipe_err;
  logic [LATENCY-1:0][31:0] pipe_rdata;

  // Byte-offset bits are carried by the byte enables, not the address.
  logic unused_bits;
  assign unused_bits = ^off[1:0];

  // A retiring response frees its slot in the same cycle, so grant may coincide with it.
  always_comb begin
    off      = bus.data_addr - ADDR_BASE;
    hit      = {2'b00, off[31:2]} < 32'(DEPTH_WORDS);
    idx      = off[2 +: IDX_W];
    rsp_now  = pipe_valid[LATENCY-1];
    grant    = bus.data_req & ~reset &
               ((32'(cnt) < 32'(MAX_OUTSTANDING)) | rsp_now);
    rsp_word = (hit & ~bus.data_wr) ? mem[idx] : 32'h0;
  end

  always_ff @(posedge clk) begin
    if (grant & hit & bus.data_wr) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.data_be[b]) begin
          mem[idx][8*b +: 8] <= bus.data_wdata[8*b +: 8];
        end
      end
    end
  end

  // Stage 0 captures the granted access; the last stage is what the requester sees.
  always_ff @(posedge clk) begin
    if (reset) begin
      pipe_valid <= '0;
      pipe_err   <= '0;
      pipe_rdata <= '0;
      cnt        <= '0;
    end else begin
      pipe_valid[0] <= grant;
      pipe_err[0]   <= grant & ~hit;
      pipe_rdata[0] <= grant ? rsp_word : 32'h0;
      for (int i = 1; i < LATENCY; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
        pipe_err[i]   <= pipe_err[i-1];
        pipe_rdata[i] <= pipe_rdata[i-1];
      end
      case ({grant, rsp_now})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  assign bus.data_gnt   = grant;
  assign bus.data_valid = pipe_valid[LATENCY-1];
  assign bus.data_error = pipe_err[LATENCY-1];
  assign bus.data_rdata = pipe_rdata[LATENCY-1];

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized scoreboard bench for data_mem_responder (LATENCY=3, MAX_OUTSTANDING=2) with
// directed store/load, byte-enable, out-of-range, throughput and mid-flight reset sequences.
`timescale 1ns/1ps
module tb_data_mem_responder;

  localparam logic [31:0] BASE  = 32'h0001_0000;
  localparam int          DEPTH = 1024;
  localparam int          LAT   = 3;
  localparam int          MAXO  = 2;

  typedef struct {
    int unsigned due;
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int unsigned cyc = 0;
  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  exp_t q[$];
  logic [31:0] ref_mem [DEPTH];

  data_mem_if bus();

  data_mem_responder #(
    .ADDR_BASE(BASE),
    .DEPTH_WORDS(DEPTH),
    .LATENCY(LAT),
    .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference memory: a store writes enabled bytes, a load reads the word, a miss touches nothing.
  task automatic modelGrant(input bit wr, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [3:0] be);
    exp_t e;
    logic [31:0] off;
    int unsigned w;
    off = addr - BASE;
    e.due = cyc + LAT;
    e.err = !(off < 32'(4 * DEPTH));
    e.rdata = 32'h0;
    if (!e.err) begin
      w = off / 4;
      if (wr) begin
        for (int b = 0; b < 4; b++)
          if (be[b]) ref_mem[w][8*b +: 8] = wdata[8*b +: 8];
      end else begin
        e.rdata = ref_mem[w];
      end
    end
    q.push_back(e);
  endtask

  task automatic applyStimulus(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [3:0] be, output int waits);
    bit granted;
    bit exp_gnt;
    bus.data_req   = 1'b1;
    bus.data_wr    = wr;
    bus.data_addr  = addr;
    bus.data_wdata = wdata;
    bus.data_be    = be;
    waits = 0;
    granted = 1'b0;
    while (!granted && waits < 20) begin
      @(negedge clk);
      exp_gnt = (q.size() < MAXO) || (q.size() > 0 && q[0].due == cyc);
      checkOutput("gnt", {31'b0, bus.data_gnt}, {31'b0, exp_gnt});
      if (bus.data_gnt === 1'b1) begin
        granted = 1'b1;
        modelGrant(wr, addr, wdata, be);
      end else begin
        waits++;
      end
      @(posedge clk);
      #1;
    end
    if (!granted) begin
      checks++;
      errors++;
      $display("[TB] FAIL gnt_timeout: got no grant, expected grant within 20 cycles");
    end
  endtask

  task automatic idleCycles(input int n);
    bus.data_req = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Responses due in the reset cycle itself are still visible; later ones are dropped.
  task automatic doReset(input int n);
    reset = 1'b1;
    repeat (n) begin
      @(negedge clk);
      checkOutput("reset_gnt", {31'b0, bus.data_gnt}, 32'h0);
      while (q.size() > 0 && q[q.size()-1].due > cyc) void'(q.pop_back());
      @(posedge clk);
      #1;
    end
    reset = 1'b0;
  endtask

  // Monitor: every valid pops the oldest expectation; idle cycles must show zero data.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (!mon_en) continue;
      if (bus.data_valid === 1'b1) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_valid: got data_valid=1, expected no response pending");
        end else begin
          e = q.pop_front();
          checkOutput("rsp_latency", cyc, e.due);
          checkOutput("rsp_error", {31'b0, bus.data_error}, {31'b0, e.err});
          checkOutput("rsp_rdata", bus.data_rdata, e.rdata);
        end
      end else begin
        checkOutput("idle_valid", {31'b0, bus.data_valid}, 32'h0);
        checkOutput("idle_error", {31'b0, bus.data_error}, 32'h0);
        checkOutput("idle_rdata", bus.data_rdata, 32'h0);
        if (q.size() > 0 && q[0].due <= cyc) begin
          e = q.pop_front();
          checks++;
          errors++;
          $display("[TB] FAIL missing_response: got data_valid=0, expected response due cycle %0d", e.due);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got no completion, expected finish within 1ms");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int waits;
    int total_waits;
    int k;
    int unsigned w;
    logic [31:0] addr;
    bus.data_req = 1'b0;
    bus.data_wr = 1'b0;
    bus.data_addr = 32'h0;
    bus.data_wdata = 32'h0;
    bus.data_be = 4'h0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'h0;

    doReset(2);
    mon_en = 1'b1;
    idleCycles(2);

    // Known contents for the region random traffic uses: words 0..15 and the last word.
    for (int i = 0; i <= 16; i++) begin
      w = (i == 16) ? DEPTH - 1 : i;
      applyStimulus(1'b1, BASE + 4 * w, $urandom, 4'hF, waits);
    end
    idleCycles(LAT + 2);

    applyStimulus(1'b1, BASE + 8, 32'hDEADBEEF, 4'hF, waits);
    applyStimulus(1'b0, BASE + 8, 32'h0, 4'h0, waits);
    idleCycles(LAT + 2);

    applyStimulus(1'b1, BASE + 12, 32'h11223344, 4'hF, waits);
    applyStimulus(1'b1, BASE + 12, 32'h0000AB00, 4'b0010, waits);
    applyStimulus(1'b0, BASE + 12, 32'h0, 4'h0, waits);
    applyStimulus(1'b1, BASE + 12, 32'hFFFFFFFF, 4'b0000, waits);
    applyStimulus(1'b0, BASE + 12, 32'h0, 4'h0, waits);
    idleCycles(LAT + 2);

    applyStimulus(1'b0, BASE + 4 * DEPTH, 32'h0, 4'h0, waits);
    applyStimulus(1'b0, BASE - 4, 32'h0, 4'h0, waits);
    applyStimulus(1'b1, BASE + 4 * DEPTH, 32'hA5A5A5A5, 4'hF, waits);
    applyStimulus(1'b1, BASE - 4, 32'h5A5A5A5A, 4'hF, waits);
    applyStimulus(1'b0, BASE, 32'h0, 4'h0, waits);
    applyStimulus(1'b0, BASE + 4 * (DEPTH - 1), 32'h0, 4'h0, waits);
    idleCycles(LAT + 2);

    // Continuous loads from an empty pipe: grants follow 1,1,0,1,1,0,1,1 -> two stall cycles.
    total_waits = 0;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b0, BASE + 4 * i, 32'h0, 4'h0, waits);
      total_waits += waits;
    end
    checkOutput("throughput_stalls", total_waits, 32'd2);
    idleCycles(LAT + 2);

    applyStimulus(1'b0, BASE + 8, 32'h0, 4'h0, waits);
    doReset(1);
    applyStimulus(1'b0, BASE + 12, 32'h0, 4'h0, waits);
    checkOutput("post_reset_wait", waits, 32'd0);
    applyStimulus(1'b0, BASE + 16, 32'h0, 4'h0, waits);
    checkOutput("post_reset_second_wait", waits, 32'd0);
    idleCycles(LAT + 2);

    for (int n = 0; n < 300; n++) begin
      k = $urandom_range(0, 8);
      if (k <= 6) begin
        w = $urandom_range(0, 16);
        if (w == 16) w = DEPTH - 1;
        addr = BASE + 4 * w + $urandom_range(0, 3);
      end else if (k == 7) begin
        addr = BASE + 4 * DEPTH + 4 * $urandom_range(0, 15);
      end else begin
        addr = BASE - 4 * $urandom_range(1, 16);
      end
      applyStimulus($urandom_range(0, 1) == 1, addr, $urandom, 4'($urandom_range(0, 15)), waits);
      if ($urandom_range(0, 3) == 0) idleCycles($urandom_range(1, 3));
    end

    idleCycles(LAT + 3);
    checkOutput("drain_empty", q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
